// File: rtl/hex_disp_pkg.sv
// hex_disp_pkg
//   Shared types and constants for the hex display scheduler.
//   - state_t      : scheduler FSM states
//   - SRC_*        : disp_src codes seen by the decimal decoder
//   - BLANK_VALUE  : out-of-range value the decoder renders as "--"
//   - is_final()   : true for the end-of-game alternating pair
package hex_disp_pkg;

    typedef enum logic [2:0] {
        S_BLANK,
        S_PLAYER,
        S_DEALER,
        S_CARD,
        S_FINAL_P,
        S_FINAL_D
    } state_t;

    localparam logic [1:0] SRC_PLAYER = 2'd0;
    localparam logic [1:0] SRC_DEALER = 2'd1;
    localparam logic [1:0] SRC_CARD   = 2'd2;
    localparam logic [1:0] SRC_BLANK  = 2'd3;

    localparam logic [5:0] BLANK_VALUE = 6'd63;

    function automatic logic is_final(input state_t s);
        return (s == S_FINAL_P) || (s == S_FINAL_D);
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// dwell_timer
//   Free-running slot timer. Counts 0..DWELL_CYCLES-1 and raises tick
//   during the terminal count, then wraps. clear forces the count back
//   to 0 so a freshly entered slot always lasts a full DWELL_CYCLES.
// Ports:
//   clk    in  system clock
//   resetn in  asynchronous active-low reset
//   clear  in  restart the slot (count <= 0 on the next edge)
//   tick   out high during the last cycle of a slot
module dwell_timer #(
    parameter int DWELL_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    output logic tick
);

    localparam int            CW   = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DWELL_CYCLES - 1);

    logic [CW-1:0] count;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of every other flop, whatever the
    // order in which the simulator evaluates the blocks.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (clear || (count == LAST)) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/hex_display_scheduler.sv
// hex_display_scheduler
//   Time-shares the two-digit decimal decoder between player score,
//   dealer score and the most recently drawn card. Player is the default
//   view, rotating to the dealer when dealer_visible; a new card pre-empts
//   the display for CARD_HOLD slots; at game end both scores alternate.
// Ports:
//   clk, resetn     clock and asynchronous active-low reset
//   player_score    live player total (6 bit, passed through unclamped)
//   dealer_score    live dealer total (6 bit, passed through unclamped)
//   card_value      card just drawn, sampled when card_valid=1
//   card_valid      one-cycle pulse: a new card was drawn
//   dealer_visible  level: dealer score may be shown
//   game_over       level: round finished
//   disp_value      registered value for the decoder (63 renders "--")
//   disp_src        registered source: 0 player, 1 dealer, 2 card, 3 blank
//   card_ack        registered one-cycle pulse: card_value was captured
module hex_display_scheduler
    import hex_disp_pkg::*;
#(
    parameter int DWELL_CYCLES = 50_000_000,
    parameter int CARD_HOLD    = 3
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [5:0] player_score,
    input  logic [5:0] dealer_score,
    input  logic [5:0] card_value,
    input  logic       card_valid,
    input  logic       dealer_visible,
    input  logic       game_over,
    output logic [5:0] disp_value,
    output logic [1:0] disp_src,
    output logic       card_ack
);

    localparam int            HW        = (CARD_HOLD > 1) ? $clog2(CARD_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(CARD_HOLD - 1);

    state_t        state, state_next;
    logic [HW-1:0] hold_cnt, hold_next;
    logic [5:0]    card_reg, card_next;
    logic          card_take;
    logic          tick;
    logic          timer_clear;
    logic [5:0]    disp_value_next;
    logic [1:0]    disp_src_next;

    // A card re-trigger keeps the state at S_CARD, so the slot timer is
    // restarted explicitly to give the new card a full hold.
    assign timer_clear = (state_next != state) || card_take;

    dwell_timer #(
        .DWELL_CYCLES (DWELL_CYCLES)
    ) u_dwell_timer (
        .clk    (clk),
        .resetn (resetn),
        .clear  (timer_clear),
        .tick   (tick)
    );

    // Next-state logic; branches are in priority order: game end, final
    // pair, card pre-emption, then per-state rotation.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no
        // path leaves it unassigned, which would infer a latch.
        state_next = state;
        hold_next  = hold_cnt;
        card_take  = 1'b0;

        if (game_over && !is_final(state)) begin
            state_next = S_FINAL_P;
        end else if (is_final(state)) begin
            if (!game_over) begin
                state_next = S_PLAYER;
            end else if (tick) begin
                state_next = (state == S_FINAL_P) ? S_FINAL_D : S_FINAL_P;
            end
        end else if (card_valid) begin
            card_take  = 1'b1;
            hold_next  = '0;
            state_next = S_CARD;
        end else begin
            case (state)
                S_BLANK: state_next = S_PLAYER;
                S_PLAYER: begin
                    if (tick && dealer_visible) begin
                        state_next = S_DEALER;
                    end
                end
                S_DEALER: begin
                    if (tick || !dealer_visible) begin
                        state_next = S_PLAYER;
                    end
                end
                S_CARD: begin
                    if (tick) begin
                        if (hold_cnt == HOLD_LAST) begin
                            state_next = S_PLAYER;
                        end else begin
                            hold_next = hold_cnt + HW'(1);
                        end
                    end
                end
                default: state_next = S_BLANK;
            endcase
        end
    end

    assign card_next = card_take ? card_value : card_reg;

    // Outputs are decoded from the next state so the registered view lines
    // up with the state register, and score inputs are re-sampled every
    // cycle so live changes appear one cycle later.
    always_comb begin
        disp_value_next = BLANK_VALUE;
        disp_src_next   = SRC_BLANK;
        case (state_next)
            S_PLAYER, S_FINAL_P: begin
                disp_value_next = player_score;
                disp_src_next   = SRC_PLAYER;
            end
            S_DEALER, S_FINAL_D: begin
                disp_value_next = dealer_score;
                disp_src_next   = SRC_DEALER;
            end
            S_CARD: begin
                disp_value_next = card_next;
                disp_src_next   = SRC_CARD;
            end
            default: begin
                disp_value_next = BLANK_VALUE;
                disp_src_next   = SRC_BLANK;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_BLANK;
            hold_cnt   <= '0;
            card_reg   <= '0;
            disp_value <= BLANK_VALUE;
            disp_src   <= SRC_BLANK;
            card_ack   <= 1'b0;
        end else begin
            state      <= state_next;
            hold_cnt   <= hold_next;
            card_reg   <= card_next;
            disp_value <= disp_value_next;
            disp_src   <= disp_src_next;
            card_ack   <= card_take;
        end
    end

endmodule

// File: doc/hex_display_scheduler.md
# hex_display_scheduler

Time-shares the single two-digit decimal card/score decoder between the player score, dealer score and the most recently drawn card. It sits between the game FSM and the decimal hex decoder. It produces one registered 6-bit value and a source code each cycle. The player score is shown by default, and the block rotates to the dealer score when the dealer score is visible. A newly drawn card pre-empts the display for a fixed hold time. At game end the display alternates between both scores.

## Interface
- DWELL_CYCLES, 50_000_000: clock cycles per display slot (1 s at 50 MHz); must be ≥2.
- CARD_HOLD, 3: number of dwell slots a new card stays on screen; must be ≥1.
- clk  in  1  system clock.
- resetn  in  1  reset, asynchronous, active-low.
- player_score  in  6  live player total, unsigned.
- dealer_score  in  6  live dealer total, unsigned.
- card_value  in  6  value of the card just drawn; sampled only when card_valid=1.
- card_valid  in  1  one-cycle pulse: new card drawn.
- dealer_visible  in  1  level; dealer score may be shown.
- game_over  in  1  level; round finished.
- disp_value  out  6  value to the decimal decoder; 6'd63 renders as "--".
- disp_src  out  2  source code: 0 = player, 1 = dealer, 2 = card, 3 = blank.
- card_ack  out  1  one-cycle pulse: card_value was captured.

## Operation
- FSM states: S_BLANK, S_PLAYER, S_DEALER, S_CARD, S_FINAL_P, S_FINAL_D.
- Outputs per state:
  - S_BLANK: disp_value=63, disp_src=3.
  - S_PLAYER and S_FINAL_P: disp_value=player_score, disp_src=0.
  - S_DEALER and S_FINAL_D: disp_value=dealer_score, disp_src=1.
  - S_CARD: disp_value=card_reg, disp_src=2.
- In score states the inputs are re-sampled every cycle, so live score changes appear without waiting for a slot boundary.
- Values are passed through unclamped. Out-of-range values are rendered "--" by the decoder.
- Slot timing: the dwell counter runs 0..DWELL_CYCLES-1 and produces a tick at the terminal count. Any state change clears the counter to 0.
- Transitions, evaluated in priority order:
  - Any state, game_over=1 and state not S_FINAL_*: go to S_FINAL_P.
  - S_FINAL_P / S_FINAL_D: toggle between them on each tick. Stay in the final pair while game_over=1; go to S_PLAYER when game_over falls.
  - Not final, card_valid=1: capture card_reg←card_value, set hold_cnt←0, pulse card_ack, go to S_CARD. This also applies from S_CARD: the card is replaced and the hold restarts.
  - S_CARD, tick: hold_cnt++. When hold_cnt reaches CARD_HOLD-1 on a tick, go to S_PLAYER.
  - S_PLAYER, tick: go to S_DEALER if dealer_visible, else remain in S_PLAYER (the counter restarts).
  - S_DEALER: tick → S_PLAYER. If dealer_visible=0, go to S_PLAYER on the next cycle.
  - S_BLANK: go to S_PLAYER unconditionally on the first clock after reset release.
- If card_valid and game_over are high in the same cycle, game_over wins. The card is dropped and card_ack stays 0. card_valid is also ignored in S_FINAL_*.

## Timing
- Reset (async, resetn=0): state=S_BLANK, disp_value=6'd63, disp_src=3, card_ack=0, card_reg=0, dwell and hold counters 0. These take effect immediately, including mid-slot or mid-card-hold.
- All outputs are registered. An input event in cycle t is visible on the outputs in cycle t+1.
- Card pre-emption: card_valid at t gives card_ack=1, disp_src=2 and disp_value=card_value(t), all at t+1.
- Card hold duration: the card is displayed for exactly CARD_HOLD×DWELL_CYCLES cycles. disp_src=0 is first seen in the cycle after the final tick.
- Slot length: each rotation slot lasts DWELL_CYCLES cycles from entry.
- Score updates: a player_score change at t appears on disp_value at t+1 while in a score state.
- card_ack never asserts for two consecutive cycles unless card_valid is high in consecutive cycles.

## Structure
- Package hex_disp_pkg:
  - state enum.
  - SRC_PLAYER/SRC_DEALER/SRC_CARD/SRC_BLANK codes.
  - BLANK_VALUE=6'd63.
- Sub-module dwell_timer (parameter DWELL_CYCLES; ports clk, resetn, clear, tick): the counter width is $clog2(DWELL_CYCLES).
- The hold counter and card_reg stay in the top level. disp_value feeds the decimal decoder directly.

## Test plan
All scenarios use DWELL_CYCLES=4 and CARD_HOLD=2.
- Reset: resetn=0 mid-run → disp_value=63 and disp_src=3 with no clock edge. After release, the first edge gives disp_src=0.
- Rotation: dealer_visible=1, player=17, dealer=12 → 4 cycles showing 17 (src 0), then 4 cycles showing 12 (src 1), repeating.
- Rotation without dealer: dealer_visible=0 → disp_src stays 0 for ≥20 cycles.
- Card pre-emption: card_valid with card_value=10 at t → at t+1 card_ack=1, disp_value=10, disp_src=2. disp_src=2 holds for exactly 8 cycles, then returns to 0.
- Card re-trigger: a second card_valid (value 7) 3 cycles into a hold → shows 7 for a fresh 8 cycles, with card_ack pulsing once per card.
- End of game: game_over rises in the same cycle as card_valid → no card_ack. disp_src alternates 0/1 every 4 cycles, and card_valid is ignored while game_over=1. When game_over falls → S_PLAYER on the next cycle.
